vga_mem_arbiter: RTL and testbench
==================================

Name: vga_mem_arbiter

Overview:
- Shares one single-port pixel/data memory between two requesters: the VGA scanout fetcher (display) and the processor (cpu).
- Issues at most one memory command per cycle and returns read data to the owning requester after fixed latency.
- Sits between HV_sync-driven pixel fetch logic, the CPU store path, and the data memory.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 8, data width (one pixel byte).
- MAX_WAIT, 16, cycles a pending cpu request waits before the starvation guard forces a grant.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_req  in  1  display read request; held until granted
- disp_addr  in  ADDR_W  display read address
- disp_urgent  in  1  display line FIFO below low watermark
- vblank  in  1  vertical blanking interval active
- disp_gnt  out  1  display request accepted this cycle (combinational)
- disp_rvalid  out  1  disp_rdata valid
- disp_rdata  out  DATA_W  display read data
- cpu_req  in  1  cpu request; held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  cpu address
- cpu_wdata  in  DATA_W  cpu write data
- cpu_gnt  out  1  cpu request accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA_W  cpu read data
- mem_en  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Handshake: req and payload are sampled when gnt=1. gnt is high for at most one requester per cycle, and is asserted only when that requester's req is high. The requester may present a new request the next cycle, so sustained throughput is 1 command per cycle.
- Latency:
  - gnt in cycle N puts mem_en, mem_we, mem_addr and mem_wdata in registers, valid in cycle N+1.
  - For a read, mem_rdata arrives in N+2 and is presented on rdata with rvalid=1 in N+2.
  - A write produces no rvalid.
- Priority, evaluated each cycle, first matching rule wins:
  1. Starvation guard fires (see Optional Feature) -> cpu.
  2. disp_urgent & disp_req -> disp.
  3. vblank & cpu_req -> cpu.
  4. Both requesting -> round robin: grant the requester not granted last (last_owner register).
  5. Single requester -> that requester.
- last_owner updates on every grant and holds when there is no grant.
- Return path: a 2-stage owner-tag shift register (OWN_NONE/OWN_DISP/OWN_CPU) steers mem_rdata. rdata outputs are registered and hold their last value when rvalid=0.
- wait_cnt:
  - Increments while cpu_req=1 and cpu_gnt=0.
  - Saturates at MAX_WAIT.
  - Clears on cpu_gnt or when cpu_req=0.
- Address passes through unmodified; range checking is not this block's job.
- Reset (any cycle, including mid-transaction):
  - gnt outputs, rvalid outputs, mem_en and mem_we go to 0.
  - mem_addr, mem_wdata and rdata outputs go to 0.
  - last_owner=OWN_CPU, so the first tie goes to display.
  - wait_cnt=0 and all tags=OWN_NONE; in-flight reads are dropped with no rvalid.
- Simultaneous events: gnt and rvalid for different transactions may coexist in the same cycle. No grant is issued while reset=1.

Optional Feature:
- Macro: VGA_ARB_STARVE_GUARD_EN.
- Defined: when wait_cnt==MAX_WAIT and cpu_req=1, cpu is granted even over an urgent display.
- Undefined: rule 1 is absent and wait_cnt is not implemented; an urgent display may starve the cpu indefinitely.

Decomposition:
- Package vga_mem_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_DISP, OWN_CPU}.
  - Localparams DEF_ADDR_W=32 and DEF_DATA_W=8.
- Sub-module vga_rd_return_pipe: the owner-tag shift register plus rdata demux, parameterised by DATA_W.

Test Plan:
- Only disp_req=1 with addr 0,1,2 on consecutive cycles -> disp_gnt=1 for 3 cycles; mem_addr 0,1,2 in cycles 1-3; disp_rvalid with the memory contents in cycles 2-4.
- Both requesting, no urgent, no vblank, after reset -> grants alternate disp, cpu, disp, cpu.
- disp_urgent=1 and vblank=1 with both requesting -> display wins every cycle. With the guard enabled, cpu_gnt fires on exactly cycle MAX_WAIT+1 (cycle 17), then display resumes.
- cpu write 0xA5 to addr 10 then cpu read of addr 10 -> mem_we=1 then 0; cpu_rvalid=1 with 0xA5 two cycles after the read grant; no disp_rvalid.
- Reset asserted one cycle after a disp read grant -> no disp_rvalid follows. After reset release, a tied request goes to display.
- vblank=1, no urgent, both requesting -> cpu granted every cycle; display granted only once cpu_req drops.

Source files
------------

// File: rtl/vga_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_mem_pkg
// Description : Shared types, defaults and round-robin helper for the
//               VGA / CPU memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    // On a tie the requester that did not win last time gets the slot.
    function automatic owner_t rr_pick(input owner_t last_owner);
        return (last_owner == OWN_DISP) ? OWN_CPU : OWN_DISP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_mem_arbiter_if
// Description : Display, CPU and memory-side signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = vga_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = vga_mem_pkg::DEF_DATA_W
) ();

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_urgent;
    logic              vblank;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and memory model side
    modport master (
        output disp_req, disp_addr, disp_urgent, vblank,
        input  disp_gnt, disp_rvalid, disp_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  disp_req, disp_addr, disp_urgent, vblank,
        output disp_gnt, disp_rvalid, disp_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/vga_rd_return_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vga_rd_return_pipe
// Description : Two-stage owner-tag shift register that steers memory read
//               data back to the display or CPU, holding rdata between reads.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rd_return_pipe
    import vga_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire                     clk,
    input  wire                     reset,
    input  wire owner_t             issue_tag_i,
    input  wire logic [DATA_W-1:0]  mem_rdata_i,
    output logic                    disp_rvalid_o,
    output logic [DATA_W-1:0]       disp_rdata_o,
    output logic                    cpu_rvalid_o,
    output logic [DATA_W-1:0]       cpu_rdata_o
);

    owner_t            tag0_q;
    owner_t            tag1_q;
    logic [DATA_W-1:0] disp_hold_q;
    logic [DATA_W-1:0] cpu_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag0_q      <= OWN_NONE;
            tag1_q      <= OWN_NONE;
            disp_hold_q <= '0;
            cpu_hold_q  <= '0;
        end else begin
            tag0_q <= issue_tag_i;
            tag1_q <= tag0_q;
            if (tag1_q == OWN_DISP) begin
                disp_hold_q <= mem_rdata_i;
            end
            if (tag1_q == OWN_CPU) begin
                cpu_hold_q <= mem_rdata_i;
            end
        end
    end

    // Read data lands in the same cycle the tag reaches stage 1, so the live
    // bus is forwarded then and the captured copy is shown afterwards.
    assign disp_rvalid_o = (tag1_q == OWN_DISP);
    assign cpu_rvalid_o  = (tag1_q == OWN_CPU);
    assign disp_rdata_o  = disp_rvalid_o ? mem_rdata_i : disp_hold_q;
    assign cpu_rdata_o   = cpu_rvalid_o  ? mem_rdata_i : cpu_hold_q;

endmodule
`default_nettype wire

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_mem_arbiter
// Description : Shares one single-port memory between VGA scanout and CPU.
//               Optional CPU starvation guard: VGA_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 16
) (
    input  wire              clk,
    input  wire              reset,
    vga_mem_arbiter_if.slave bus
);

    if (ADDR_W < 1 || DATA_W < 1 || MAX_WAIT < 1) begin : g_param_check
        $error("vga_mem_arbiter: ADDR_W, DATA_W and MAX_WAIT must be >= 1");
    end

    logic              disp_gnt;
    logic              cpu_gnt;
    logic              guard_fire;
    owner_t            issue_tag;
    owner_t            last_owner_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

`ifdef VGA_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;

    assign guard_fire = bus.cpu_req && (wait_cnt_q == WAIT_W'(MAX_WAIT));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.cpu_req || cpu_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign guard_fire = 1'b0;
`endif

    always_comb begin
        disp_gnt = 1'b0;
        cpu_gnt  = 1'b0;
        if (!reset) begin
            if (guard_fire) begin
                cpu_gnt = 1'b1;
            end else if (bus.disp_urgent && bus.disp_req) begin
                disp_gnt = 1'b1;
            end else if (bus.vblank && bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (bus.disp_req && bus.cpu_req) begin
                if (rr_pick(last_owner_q) == OWN_CPU) begin
                    cpu_gnt = 1'b1;
                end else begin
                    disp_gnt = 1'b1;
                end
            end else if (bus.disp_req) begin
                disp_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    // Writes return nothing, so only reads carry an owner tag down the pipe.
    always_comb begin
        issue_tag = OWN_NONE;
        if (disp_gnt) begin
            issue_tag = OWN_DISP;
        end else if (cpu_gnt && !bus.cpu_we) begin
            issue_tag = OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= OWN_CPU;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            mem_en_q <= disp_gnt || cpu_gnt;
            mem_we_q <= cpu_gnt && bus.cpu_we;
            if (disp_gnt) begin
                last_owner_q <= OWN_DISP;
                mem_addr_q   <= bus.disp_addr;
            end else if (cpu_gnt) begin
                last_owner_q <= OWN_CPU;
                mem_addr_q   <= bus.cpu_addr;
                mem_wdata_q  <= bus.cpu_wdata;
            end
        end
    end

    assign bus.disp_gnt  = disp_gnt;
    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    vga_rd_return_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_return_pipe (
        .clk           (clk),
        .reset         (reset),
        .issue_tag_i   (issue_tag),
        .mem_rdata_i   (bus.mem_rdata),
        .disp_rvalid_o (bus.disp_rvalid),
        .disp_rdata_o  (bus.disp_rdata),
        .cpu_rvalid_o  (bus.cpu_rvalid),
        .cpu_rdata_o   (bus.cpu_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_mem_arbiter
// Description : Directed self-checking bench for vga_mem_arbiter with a
//               one-cycle-latency byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 16;

    logic clk;
    logic reset;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    vga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back as (addr ^ 0x5A)
    logic [7:0] mem_data    [256];
    bit         mem_written [256];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem_data[bus.mem_addr[7:0]]    <= bus.mem_wdata;
                mem_written[bus.mem_addr[7:0]] <= 1'b1;
            end else begin
                bus.mem_rdata <= mem_written[bus.mem_addr[7:0]] ?
                                 mem_data[bus.mem_addr[7:0]] :
                                 (bus.mem_addr[7:0] ^ 8'h5A);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        bus.disp_req    = 1'b0;
        bus.disp_addr   = '0;
        bus.disp_urgent = 1'b0;
        bus.vblank      = 1'b0;
        bus.cpu_req     = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
    endtask

    task automatic reset_pulse();
        idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.disp_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.disp_addr = 32'd7; bus.cpu_addr = 32'd9; bus.cpu_wdata = 8'hFF;
        next_cycle();
        next_cycle();
        settle();
        chk_cnt++; if (bus.disp_gnt !== 1'b0) $display("FAIL reset_disp_gnt: got %b expected 0", bus.disp_gnt); else pass_cnt++;
        chk_cnt++; if (bus.cpu_gnt !== 1'b0) $display("FAIL reset_cpu_gnt: got %b expected 0", bus.cpu_gnt); else pass_cnt++;
        chk_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b expected 0", bus.mem_en); else pass_cnt++;
        chk_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); else pass_cnt++;
        chk_cnt++; if (bus.mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else pass_cnt++;
        chk_cnt++; if (bus.mem_wdata !== 8'd0) $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); else pass_cnt++;
        chk_cnt++; if (bus.disp_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b%b expected 00", bus.disp_rvalid, bus.cpu_rvalid); else pass_cnt++;
        chk_cnt++; if (bus.disp_rdata !== 8'd0 || bus.cpu_rdata !== 8'd0) $display("FAIL reset_rdata: got %h/%h expected 00/00", bus.disp_rdata, bus.cpu_rdata); else pass_cnt++;
        idle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_disp_stream();
        bit         exp_gnt [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bit         exp_en  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit         exp_rv  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_rd  [6] = '{8'h00, 8'h00, 8'h5A, 8'h5B, 8'h58, 8'h58};
        for (int c = 0; c < 6; c++) begin
            bus.disp_req  = (c < 3);
            bus.disp_addr = (c < 3) ? 32'(c) : 32'd0;
            settle();
            chk_cnt++; if (bus.disp_gnt !== exp_gnt[c] || bus.cpu_gnt !== 1'b0) $display("FAIL stream_gnt c%0d: got disp=%b cpu=%b expected disp=%b cpu=0", c, bus.disp_gnt, bus.cpu_gnt, exp_gnt[c]); else pass_cnt++;
            chk_cnt++; if (bus.mem_en !== exp_en[c]) $display("FAIL stream_mem_en c%0d: got %b expected %b", c, bus.mem_en, exp_en[c]); else pass_cnt++;
            if (c >= 1 && c <= 3) begin
                chk_cnt++; if (bus.mem_addr !== 32'(c - 1) || bus.mem_we !== 1'b0) $display("FAIL stream_mem_addr c%0d: got %0d we=%b expected %0d we=0", c, bus.mem_addr, bus.mem_we, c - 1); else pass_cnt++;
            end
            chk_cnt++; if (bus.disp_rvalid !== exp_rv[c] || bus.cpu_rvalid !== 1'b0) $display("FAIL stream_rvalid c%0d: got disp=%b cpu=%b expected disp=%b cpu=0", c, bus.disp_rvalid, bus.cpu_rvalid, exp_rv[c]); else pass_cnt++;
            if (c >= 2) begin
                chk_cnt++; if (bus.disp_rdata !== exp_rd[c]) $display("FAIL stream_rdata c%0d: got %h expected %h", c, bus.disp_rdata, exp_rd[c]); else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        reset_pulse();
        bus.disp_req = 1'b1; bus.disp_addr = 32'd3;
        bus.cpu_req  = 1'b1; bus.cpu_addr  = 32'd5; bus.cpu_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk_cnt++; if (bus.disp_gnt !== (c % 2 == 0) || bus.cpu_gnt !== (c % 2 == 1)) $display("FAIL rr_gnt c%0d: got disp=%b cpu=%b expected disp=%b cpu=%b", c, bus.disp_gnt, bus.cpu_gnt, (c % 2 == 0), (c % 2 == 1)); else pass_cnt++;
            if (c >= 1) begin
                chk_cnt++; if (bus.mem_addr !== ((c % 2 == 1) ? 32'd3 : 32'd5)) $display("FAIL rr_mem_addr c%0d: got %0d expected %0d", c, bus.mem_addr, (c % 2 == 1) ? 3 : 5); else pass_cnt++;
            end
            next_cycle();
        end
        idle();
        repeat (3) next_cycle();
    endtask

    task automatic test_urgent_starve();
        bit exp_cpu;
        reset_pulse();
        bus.disp_urgent = 1'b1; bus.vblank = 1'b1;
        bus.disp_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
        for (int k = 1; k <= 20; k++) begin
`ifdef VGA_ARB_STARVE_GUARD_EN
            exp_cpu = (k == MAX_WAIT + 1);
`else
            exp_cpu = 1'b0;
`endif
            settle();
            chk_cnt++; if (bus.cpu_gnt !== exp_cpu || bus.disp_gnt !== !exp_cpu) $display("FAIL urgent_gnt cycle%0d: got disp=%b cpu=%b expected disp=%b cpu=%b", k, bus.disp_gnt, bus.cpu_gnt, !exp_cpu, exp_cpu); else pass_cnt++;
            next_cycle();
        end
        idle();
        repeat (3) next_cycle();
    endtask

    task automatic test_cpu_write_read();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'd10; bus.cpu_wdata = 8'hA5;
        settle();
        chk_cnt++; if (bus.cpu_gnt !== 1'b1) $display("FAIL wr_cpu_gnt: got %b expected 1", bus.cpu_gnt); else pass_cnt++;
        next_cycle();
        bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h00;
        settle();
        chk_cnt++; if (bus.cpu_gnt !== 1'b1) $display("FAIL rd_cpu_gnt: got %b expected 1", bus.cpu_gnt); else pass_cnt++;
        chk_cnt++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) $display("FAIL wr_mem_cmd: got en=%b we=%b expected en=1 we=1", bus.mem_en, bus.mem_we); else pass_cnt++;
        chk_cnt++; if (bus.mem_addr !== 32'd10 || bus.mem_wdata !== 8'hA5) $display("FAIL wr_mem_payload: got addr=%0d wdata=%h expected addr=10 wdata=a5", bus.mem_addr, bus.mem_wdata); else pass_cnt++;
        next_cycle();
        bus.cpu_req = 1'b0;
        settle();
        chk_cnt++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd10) $display("FAIL rd_mem_cmd: got en=%b we=%b addr=%0d expected en=1 we=0 addr=10", bus.mem_en, bus.mem_we, bus.mem_addr); else pass_cnt++;
        chk_cnt++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b expected 0", bus.cpu_rvalid); else pass_cnt++;
        next_cycle();
        settle();
        chk_cnt++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hA5) $display("FAIL rd_cpu_return: got rvalid=%b rdata=%h expected rvalid=1 rdata=a5", bus.cpu_rvalid, bus.cpu_rdata); else pass_cnt++;
        chk_cnt++; if (bus.disp_rvalid !== 1'b0) $display("FAIL rd_no_disp_rvalid: got %b expected 0", bus.disp_rvalid); else pass_cnt++;
        next_cycle();
        settle();
        chk_cnt++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 8'hA5) $display("FAIL rd_cpu_hold: got rvalid=%b rdata=%h expected rvalid=0 rdata=a5", bus.cpu_rvalid, bus.cpu_rdata); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        bus.disp_req = 1'b1; bus.disp_addr = 32'd1;
        settle();
        chk_cnt++; if (bus.disp_gnt !== 1'b1) $display("FAIL mid_disp_gnt: got %b expected 1", bus.disp_gnt); else pass_cnt++;
        next_cycle();
        idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        bus.disp_req = 1'b1; bus.disp_addr = 32'd1;
        bus.cpu_req  = 1'b1; bus.cpu_addr  = 32'd2;
        settle();
        chk_cnt++; if (bus.disp_rvalid !== 1'b0 || bus.disp_rdata !== 8'd0) $display("FAIL mid_dropped: got rvalid=%b rdata=%h expected rvalid=0 rdata=00", bus.disp_rvalid, bus.disp_rdata); else pass_cnt++;
        chk_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL mid_mem_en: got %b expected 0", bus.mem_en); else pass_cnt++;
        chk_cnt++; if (bus.disp_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) $display("FAIL mid_tie_gnt: got disp=%b cpu=%b expected disp=1 cpu=0", bus.disp_gnt, bus.cpu_gnt); else pass_cnt++;
        next_cycle();
        idle();
        settle();
        chk_cnt++; if (bus.disp_rvalid !== 1'b0) $display("FAIL mid_no_late_rvalid: got %b expected 0", bus.disp_rvalid); else pass_cnt++;
        next_cycle();
        settle();
        chk_cnt++; if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== 8'h5B) $display("FAIL mid_after_reset_read: got rvalid=%b rdata=%h expected rvalid=1 rdata=5b", bus.disp_rvalid, bus.disp_rdata); else pass_cnt++;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_vblank();
        bus.vblank = 1'b1;
        bus.disp_req = 1'b1; bus.disp_addr = 32'd4;
        bus.cpu_req  = 1'b1; bus.cpu_addr  = 32'd6; bus.cpu_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk_cnt++; if (bus.cpu_gnt !== 1'b1 || bus.disp_gnt !== 1'b0) $display("FAIL vblank_gnt c%0d: got disp=%b cpu=%b expected disp=0 cpu=1", c, bus.disp_gnt, bus.cpu_gnt); else pass_cnt++;
            next_cycle();
        end
        bus.cpu_req = 1'b0;
        settle();
        chk_cnt++; if (bus.disp_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) $display("FAIL vblank_disp_after: got disp=%b cpu=%b expected disp=1 cpu=0", bus.disp_gnt, bus.cpu_gnt); else pass_cnt++;
        next_cycle();
        idle();
        repeat (3) next_cycle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_disp_stream();
        test_round_robin();
        test_urgent_starve();
        test_cpu_write_read();
        test_reset_midflight();
        test_vblank();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", chk_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
